// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM stage: variable-latency req/ack handshake.
// The master side is the access unit, the slave side is the data memory.
interface mem_access_unit_if #(
  parameter int PROC_BITS     = 32,
  parameter int MEM_ADDR_BITS = 10
);
  logic                     req;
  logic                     we;
  logic [MEM_ADDR_BITS-1:0] addr;
  logic [PROC_BITS-1:0]     wdata;
  logic [3:0]               wstrb;
  logic                     ack;
  logic [PROC_BITS-1:0]     rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one access per instruction, filters loads and
// stalls the pipeline while in flight. Optional ack watchdog: define MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int PROC_BITS      = 32,
  parameter int MEM_ADDR_BITS  = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PROC_BITS-1:0] i_alu_result,
  input  logic [PROC_BITS-1:0] i_rt_data,
  input  logic                 i_MemRead,
  input  logic                 i_MemWrite,
  input  logic [2:0]           i_ls_filter_op,
  output logic                 o_stall,
  output logic [PROC_BITS-1:0] o_load_data,
  output logic                 o_misaligned,
  output logic                 o_mem_error,
  mem_access_unit_if.master    mem
);

  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b011;
  localparam logic [2:0] OP_HU = 3'b100;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     req_q, req_d;
  logic                     we_q, we_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PROC_BITS-1:0]     wdata_q, wdata_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic [2:0]               op_q, op_d;
  logic [1:0]               lane_q, lane_d;
  logic [PROC_BITS-1:0]     load_data_q, load_data_d;

  logic                 access, is_byte, is_half, misaligned, is_write;
  logic [1:0]           lane;
  logic [PROC_BITS-1:0] st_wdata;
  logic [3:0]           st_wstrb;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [PROC_BITS-1:0] filtered;
  logic                 unused_addr_bits;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_BITS = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                error_q, error_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  assign unused_addr_bits = ^i_alu_result[PROC_BITS-1:MEM_ADDR_BITS+2];

  always_comb begin
    access   = i_MemRead | i_MemWrite;
    is_write = i_MemWrite & ~i_MemRead;
    lane     = i_alu_result[1:0];
    is_byte  = (i_ls_filter_op == OP_B) || (i_ls_filter_op == OP_BU);
    is_half  = (i_ls_filter_op == OP_H) || (i_ls_filter_op == OP_HU);
    misaligned = (is_half && lane[0]) || (!is_byte && !is_half && lane != 2'b00);
    if (is_byte) begin
      st_wdata = {4{i_rt_data[7:0]}};
      st_wstrb = 4'b0001 << lane;
    end else if (is_half) begin
      st_wdata = {2{i_rt_data[15:0]}};
      st_wstrb = lane[1] ? 4'b1100 : 4'b0011;
    end else begin
      st_wdata = i_rt_data;
      st_wstrb = 4'b1111;
    end
  end

  // Load filtering works on the latched lane/op, so EX/MEM changes during REQ are harmless.
  always_comb begin
    rd_byte = 8'(mem.rdata >> {lane_q, 3'b000});
    rd_half = lane_q[1] ? mem.rdata[16 +: 16] : mem.rdata[0 +: 16];
    case (op_q)
      OP_B:    filtered = {{(PROC_BITS-8){rd_byte[7]}}, rd_byte};
      OP_BU:   filtered = {{(PROC_BITS-8){1'b0}}, rd_byte};
      OP_H:    filtered = {{(PROC_BITS-16){rd_half[15]}}, rd_half};
      OP_HU:   filtered = {{(PROC_BITS-16){1'b0}}, rd_half};
      default: filtered = mem.rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    op_d        = op_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    error_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = is_write;
          addr_d  = i_alu_result[MEM_ADDR_BITS+1:2];
          wdata_d = st_wdata;
          wstrb_d = is_write ? st_wstrb : 4'b0000;
          op_d    = i_ls_filter_op;
          lane_d  = lane;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (mem.ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) load_data_d = filtered;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          error_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      op_q        <= 3'b000;
      lane_q      <= 2'b00;
      load_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      error_q     <= error_d;
`endif
    end
  end

  assign o_stall      = ((state_q == IDLE) && access && !misaligned) || (state_q == REQ);
  assign o_misaligned = (state_q == IDLE) && access && misaligned;
  assign o_load_data  = load_data_q;
  assign mem.req      = req_q;
  assign mem.we       = we_q;
  assign mem.addr     = addr_q;
  assign mem.wdata    = wdata_q;
  assign mem.wstrb    = wstrb_q;
`ifdef MEM_TIMEOUT_EN
  assign o_mem_error  = error_q;
`else
  assign o_mem_error  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores, misaligned and reset cases.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] rt_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  filter_op = 3'b000;
  logic        stall, misaligned, mem_error;
  logic [31:0] load_data;

  int compared = 0;
  int mismatched = 0;

  int          ack_delay = 0;
  bit          ack_suppress = 1'b0;
  bit          spurious_ack = 1'b0;
  logic [31:0] rdata_val = '0;
  int          wait_cnt = 0;

  typedef struct {
    logic [9:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] load;
  } exp_t;
  exp_t sb_q[$];

  mem_access_unit_if #(.PROC_BITS(32), .MEM_ADDR_BITS(10)) mem ();

  mem_access_unit #(.PROC_BITS(32), .MEM_ADDR_BITS(10), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i_alu_result(alu_result), .i_rt_data(rt_data),
    .i_MemRead(mem_read), .i_MemWrite(mem_write), .i_ls_filter_op(filter_op),
    .o_stall(stall), .o_load_data(load_data), .o_misaligned(misaligned),
    .o_mem_error(mem_error), .mem(mem)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Memory responder: acks after ack_delay extra REQ cycles unless suppressed.
  initial begin
    mem.ack   = 1'b0;
    mem.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem.rdata = rdata_val;
      if (mem.req && !ack_suppress) begin
        mem.ack = (wait_cnt == ack_delay);
        wait_cnt++;
      end else begin
        mem.ack  = spurious_ack;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: checks request fields on each accepted access, then the load result in DONE.
  initial begin
    exp_t cur;
    bit   check_done = 1'b0;
    forever begin
      @(negedge clk);
      if (check_done) begin
        checkOutput("done_load_data", load_data, cur.load);
        checkOutput("done_stall", {31'b0, stall}, 32'd0);
        check_done = 1'b0;
      end
      if (rst && mem.req && mem.ack) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_access", 32'd1, 32'd0);
        end else begin
          cur = sb_q.pop_front();
          checkOutput("req_addr", {22'b0, mem.addr}, {22'b0, cur.addr});
          checkOutput("req_we", {31'b0, mem.we}, {31'b0, cur.we});
          checkOutput("req_wstrb", {28'b0, mem.wstrb}, {28'b0, cur.wstrb});
          if (cur.we) checkOutput("req_wdata", mem.wdata, cur.wdata);
          check_done = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] rt, input bit rd, input bit wr,
                               input logic [2:0] op, input logic [31:0] rdata, input int delay,
                               input logic [9:0] e_addr, input bit e_we, input logic [31:0] e_wdata,
                               input logic [3:0] e_wstrb, input logic [31:0] e_load, input bit scramble);
    exp_t        e;
    int          n;
    bit          seen;
    bit          unstable;
    logic [9:0]  f_addr;
    logic [31:0] f_wdata;
    e.addr = e_addr; e.we = e_we; e.wdata = e_wdata; e.wstrb = e_wstrb; e.load = e_load;
    sb_q.push_back(e);
    ack_delay  = delay;
    rdata_val  = rdata;
    alu_result = addr;
    rt_data    = rt;
    mem_read   = rd;
    mem_write  = wr;
    filter_op  = op;
    n = 0; seen = 1'b0; unstable = 1'b0; f_addr = '0; f_wdata = '0;
    @(negedge clk);
    while (stall && n < 64) begin
      n++;
      if (mem.req) begin
        if (!seen) begin
          f_addr = mem.addr; f_wdata = mem.wdata; seen = 1'b1;
        end else if (mem.addr !== f_addr || mem.wdata !== f_wdata) begin
          unstable = 1'b1;
        end
        if (scramble) begin
          alu_result = 32'h0000_0123;
          rt_data    = 32'h5555_5555;
        end
      end
      @(negedge clk);
    end
    checkOutput("stall_cycles", n, delay + 2);
    if (scramble) checkOutput("req_stable", {31'b0, unstable}, 32'd0);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic checkMisaligned(input logic [31:0] addr, input logic [2:0] op);
    bit req_seen = 1'b0;
    alu_result = addr;
    filter_op  = op;
    mem_read   = 1'b1;
    @(negedge clk);
    checkOutput("misaligned_flag", {31'b0, misaligned}, 32'd1);
    checkOutput("misaligned_stall", {31'b0, stall}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (mem.req) req_seen = 1'b1;
    end
    checkOutput("misaligned_no_req", {31'b0, req_seen}, 32'd0);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    checkOutput("reset_req", {31'b0, mem.req}, 32'd0);
    checkOutput("reset_load", load_data, 32'd0);
    checkOutput("reset_wstrb", {28'b0, mem.wstrb}, 32'd0);
    checkOutput("reset_addr_wdata", {mem.wdata[21:0], mem.addr}, 32'd0);
    checkOutput("reset_error", {31'b0, mem_error}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back loads and stores.
    applyStimulus(32'h10, 32'h0, 1, 0, 3'b000, 32'hDEADBEEF, 0, 10'd4, 0, 32'h0, 4'b0000, 32'hDEADBEEF, 0);
    applyStimulus(32'h13, 32'h0, 1, 0, 3'b001, 32'h80112233, 0, 10'd4, 0, 32'h0, 4'b0000, 32'hFFFFFF80, 0);
    applyStimulus(32'h13, 32'h0, 1, 0, 3'b011, 32'h80112233, 0, 10'd4, 0, 32'h0, 4'b0000, 32'h00000080, 0);
    applyStimulus(32'h06, 32'h0000ABCD, 0, 1, 3'b010, 32'h0, 0, 10'd1, 1, 32'hABCDABCD, 4'b1100, 32'h00000080, 0);
    applyStimulus(32'h02, 32'h0, 1, 0, 3'b010, 32'h80017FFE, 1, 10'd0, 0, 32'h0, 4'b0000, 32'hFFFF8001, 0);
    applyStimulus(32'h00, 32'h0, 1, 0, 3'b100, 32'h8001F00F, 0, 10'd0, 0, 32'h0, 4'b0000, 32'h0000F00F, 0);
    applyStimulus(32'h21, 32'h123456A5, 0, 1, 3'b001, 32'h0, 2, 10'd8, 1, 32'hA5A5A5A5, 4'b0010, 32'h0000F00F, 0);
    applyStimulus(32'h3FC, 32'h11111111, 1, 1, 3'b000, 32'h0BADF00D, 0, 10'd255, 0, 32'h0, 4'b0000, 32'h0BADF00D, 0);
    applyStimulus(32'h08, 32'h0, 1, 0, 3'b111, 32'h13579BDF, 0, 10'd2, 0, 32'h0, 4'b0000, 32'h13579BDF, 0);
    applyStimulus(32'h40, 32'hCAFEBABE, 0, 1, 3'b000, 32'h0, 5, 10'd16, 1, 32'hCAFEBABE, 4'b1111, 32'h13579BDF, 1);

    checkMisaligned(32'h11, 3'b000);
    checkMisaligned(32'h05, 3'b010);

    // Ack outside REQ must be ignored.
    spurious_ack = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("spurious_stall", {31'b0, stall}, 32'd0);
    checkOutput("spurious_load", load_data, 32'h13579BDF);
    spurious_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    begin
      int n = 0;
      @(posedge clk);
      #1;
      ack_suppress = 1'b1;
      alu_result = 32'h0C; filter_op = 3'b000; mem_read = 1'b1;
      @(negedge clk);
      while (stall && n < 64) begin
        n++;
        @(negedge clk);
      end
      checkOutput("timeout_stall_cycles", n, 5);
      checkOutput("timeout_error_pulse", {31'b0, mem_error}, 32'd1);
      checkOutput("timeout_req_dropped", {31'b0, mem.req}, 32'd0);
      checkOutput("timeout_load_kept", load_data, 32'h13579BDF);
      @(posedge clk);
      #1;
      mem_read = 1'b0;
      @(negedge clk);
      checkOutput("timeout_error_cleared", {31'b0, mem_error}, 32'd0);
      ack_suppress = 1'b0;
    end
`else
    checkOutput("error_tied_low", {31'b0, mem_error}, 32'd0);
`endif

    // Reset while waiting for an ack.
    @(posedge clk);
    #1;
    ack_suppress = 1'b1;
    alu_result = 32'h40; rt_data = 32'h01020304; filter_op = 3'b000; mem_write = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_req", {31'b0, mem.req}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("async_reset_req", {31'b0, mem.req}, 32'd0);
    checkOutput("async_reset_load", load_data, 32'd0);
    mem_write = 1'b0;
    #1;
    checkOutput("async_reset_idle", {31'b0, stall}, 32'd0);
    ack_suppress = 1'b0;
    spurious_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("late_ack_req", {31'b0, mem.req}, 32'd0);
    checkOutput("late_ack_stall", {31'b0, stall}, 32'd0);
    checkOutput("late_ack_load", load_data, 32'd0);
    spurious_ack = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Consumer of the EX/MEM pipeline register's outputs: executes the load or store requested by the instruction currently in MEM against a data memory with a variable-latency req/ack handshake. Applies load/store filtering (byte/half/word, signed/unsigned), produces the load result for MEM/WB, and stalls the pipeline through the hazard unit while an access is in flight. Sits between EX_MEM and MEM_WB; drives the data-memory port.

## Interface
- PROC_BITS, 32, datapath width (only 32 supported)
- MEM_ADDR_BITS, 10, data-memory word-address width
- TIMEOUT_CYCLES, 255, ack watchdog limit (used only with MEM_TIMEOUT_EN)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_alu_result  in  PROC_BITS  byte address from EX/MEM
- i_rt_data  in  PROC_BITS  store data from EX/MEM
- i_MemRead / i_MemWrite  in  1  access request from EX/MEM (both high = treated as read)
- i_ls_filter_op  in  3  width/sign: 000 W, 001 B signed, 010 H signed, 011 BU, 100 HU, others = W
- o_stall  out  1  to hazard unit; high = hold PC/IF_ID/ID_EX/EX_MEM, bubble MEM_WB
- o_load_data  out  PROC_BITS  filtered load result to MEM/WB
- o_misaligned  out  1  combinational: current access misaligned, not issued
- o_mem_req / o_mem_we  out  1  memory request / write qualifier
- o_mem_addr  out  MEM_ADDR_BITS  word address = i_alu_result[MEM_ADDR_BITS+1:2]
- o_mem_wdata  out  PROC_BITS  lane-replicated store data
- o_mem_wstrb  out  4  byte enables, little-endian
- i_mem_ack  in  1  access complete; rdata valid same cycle for reads
- i_mem_rdata  in  PROC_BITS  read word
- o_mem_error  out  1  timeout abort flag (tied 0 without MEM_TIMEOUT_EN)

## Operation
- FSM states IDLE, REQ, DONE; reset state IDLE.
- access = i_MemRead | i_MemWrite. Misaligned: half with addr[0]=1, word with addr[1:0]≠0.
- IDLE: access & aligned -> latch addr/we/wdata/wstrb/op/lane, go REQ. access & misaligned -> o_misaligned=1, no request, stay IDLE, no stall. Else stay IDLE.
- REQ: o_mem_req=1 with latched fields held stable until ack. Ack sampled at rising edge: read -> register filtered data into o_load_data; go DONE.
- DONE: o_stall=0 for exactly one cycle (pipeline advances, MEM_WB captures o_load_data), then IDLE.
- o_stall = (IDLE & access & aligned) | REQ.
- Load filter: lane = addr[1:0]; byte = rdata[8*lane+7:8*lane], half = rdata[16*addr[1]+15:16*addr[1]]; signed ops sign-extend, unsigned zero-extend, W passes through.
- Store: byte -> wdata={4{rt[7:0]}}, wstrb=1<<lane; half -> wdata={2{rt[15:0]}}, wstrb=addr[1]?1100:0011; word -> wdata=rt, wstrb=1111. Reads drive wstrb=0000, o_mem_we=0.
- o_load_data updates only on completed reads; stores and misaligned accesses leave it unchanged.

## Timing
- Reset (async, immediate): state IDLE, o_mem_req/o_mem_we/o_mem_error 0, o_mem_addr/o_mem_wdata/o_load_data 0, o_mem_wstrb 0000. Reset mid-REQ drops o_mem_req without waiting for ack; late ack afterwards is ignored.
- Zero-wait memory (ack in first REQ cycle): instruction occupies MEM 3 cycles, o_stall high 2 cycles.
- Ack after N extra cycles: o_stall high N+2 cycles.
- i_mem_ack while not in REQ: ignored.
- Inputs are held by EX_MEM while o_stall=1; changes on them during REQ are ignored (latched copy used).
- Back-to-back accesses: new instruction evaluated in IDLE the cycle after DONE; no gap beyond DONE.

## Configuration
- MEM_TIMEOUT_EN defined: 8-bit-or-wider counter clears on REQ entry, increments each REQ cycle; reaching TIMEOUT_CYCLES without ack -> drop req, pulse o_mem_error one cycle, go DONE, o_load_data unchanged. Sticky clear only on reset is not used; error is a pulse.
- Undefined: no counter, REQ waits indefinitely, o_mem_error tied 0.

## Test plan
- LW addr 0x10, ack in first REQ cycle, rdata 0xDEADBEEF -> o_mem_addr=4, o_stall 2 cycles, o_load_data=0xDEADBEEF in DONE.
- LB (001) addr 0x13, rdata 0x80112233 -> o_load_data=0xFFFFFF80; same with LBU (011) -> 0x00000080.
- SH addr 0x06, rt 0x0000ABCD -> o_mem_we=1, wstrb=1100, wdata=0xABCDABCD, addr=1; o_load_data unchanged.
- LW addr 0x11 -> o_misaligned=1, o_mem_req never asserts, o_stall=0.
- SW with ack delayed 5 cycles -> o_stall high 7 cycles, req/addr/wdata stable throughout; rst pulled low during wait -> o_mem_req falls immediately, state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> o_mem_error pulse after 4 REQ cycles, req drops, stall releases next cycle.
